// File: rtl/dense_mac_sequencer.sv
// Single-neuron dense layer: one shared signed multiplier/accumulator steps
// through N_IN weight*input terms, adds the bias, and reports the result
// with the ap_start/ap_done/ap_idle/ap_ready handshake.
module dense_mac_sequencer #(
    parameter int unsigned        N_IN  = 2,
    parameter int unsigned        DW    = 16,
    parameter int unsigned        FRAC  = 10,
    parameter logic [N_IN*DW-1:0] W_RST = {16'sd304, -16'sd288},
    parameter logic [DW-1:0]      B_RST = 16'sd157,
    localparam int unsigned       AW    = $clog2(N_IN + 1)
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst,
    input  logic                 ap_start,
    output logic                 ap_done,
    output logic                 ap_idle,
    output logic                 ap_ready,
    input  logic                 input_V_ap_vld,
    input  logic [N_IN*DW-1:0]   input_V,
    input  logic                 cfg_we,
    input  logic [AW-1:0]        cfg_addr,
    input  logic [DW-1:0]        cfg_wdata,
    output logic                 cfg_err,
    output logic [DW-1:0]        out_V,
    output logic                 out_V_ap_vld
);

    localparam int unsigned IW = (N_IN > 1) ? $clog2(N_IN) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_BIAS,
        S_DONE
    } state_e;

    state_e                 state_q, state_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [DW-1:0]          acc_q, acc_d;
    logic [DW-1:0]          out_q, out_d;
    logic [N_IN*DW-1:0]     x_q, x_d;
    logic                   cfg_err_q, cfg_err_d;
    logic [DW-1:0]          w_q [N_IN];
    logic [DW-1:0]          bias_q;

    logic                   capture;
    logic                   last;
    logic                   cfg_ok;
    logic signed [DW-1:0]   w_sel;
    logic signed [DW-1:0]   x_sel;
    logic signed [2*DW-1:0] prod;
    logic [DW-1:0]          term;
    logic                   unused_prod;

    assign capture = (state_q == S_IDLE) && ap_start && input_V_ap_vld;
    assign last    = (idx_q == IW'(N_IN - 1));
    assign cfg_ok  = cfg_we && (state_q == S_IDLE) && (cfg_addr <= AW'(N_IN));

    // Operand mux: pick weight and input for the current term index
    always_comb begin
        w_sel = '0;
        x_sel = '0;
        for (int unsigned i = 0; i < N_IN; i++) begin
            if (idx_q == IW'(i)) begin
                w_sel = w_q[i];
                x_sel = x_q[i*DW +: DW];
            end
        end
    end

    // Bit-select of the full product is a floor shift that drops the high bits
    assign prod        = w_sel * x_sel;
    assign term        = prod[FRAC+DW-1:FRAC];
    assign unused_prod = ^prod;

    // FSM next-state and handshake decode
    always_comb begin
        state_d  = state_q;
        ap_ready = 1'b0;
        ap_idle  = 1'b0;
        ap_done  = 1'b0;
        case (state_q)
            S_IDLE: begin
                ap_idle = 1'b1;
                if (capture) begin
                    ap_ready = 1'b1;
                    state_d  = S_MAC;
                end
            end
            S_MAC: begin
                if (last) begin
                    state_d = S_BIAS;
                end
            end
            S_BIAS: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                ap_done = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath next-state: capture, accumulate, bias add, config error flag
    always_comb begin
        x_d       = x_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        out_d     = out_q;
        cfg_err_d = cfg_we && !cfg_ok;
        case (state_q)
            S_IDLE: begin
                if (capture) begin
                    x_d   = input_V;
                    acc_d = '0;
                    idx_d = '0;
                end
            end
            S_MAC: begin
                acc_d = acc_q + term;
                idx_d = last ? '0 : idx_q + 1'b1;
            end
            S_BIAS: begin
                out_d = acc_q + bias_q;
            end
            default: begin
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            acc_q     <= '0;
            out_q     <= '0;
            x_q       <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            acc_q     <= acc_d;
            out_q     <= out_d;
            x_q       <= x_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    // Weight and bias storage, written only from IDLE
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            for (int unsigned i = 0; i < N_IN; i++) begin
                w_q[i] <= W_RST[i*DW +: DW];
            end
            bias_q <= B_RST;
        end else if (cfg_ok) begin
            for (int unsigned i = 0; i < N_IN; i++) begin
                if (cfg_addr == AW'(i)) begin
                    w_q[i] <= cfg_wdata;
                end
            end
            if (cfg_addr == AW'(N_IN)) begin
                bias_q <= cfg_wdata;
            end
        end
    end

    assign out_V        = out_q;
    assign out_V_ap_vld = ap_done;
    assign cfg_err      = cfg_err_q;

endmodule

// File: tb/tb_dense_mac_sequencer.sv
// Directed bench for dense_mac_sequencer with hand-computed results.
module tb_dense_mac_sequencer;

    localparam int unsigned N_IN = 2;
    localparam int unsigned DW   = 16;

    logic              ap_clk;
    logic              ap_rst;
    logic              ap_start;
    logic              ap_done;
    logic              ap_idle;
    logic              ap_ready;
    logic              input_V_ap_vld;
    logic [N_IN*DW-1:0] input_V;
    logic              cfg_we;
    logic [1:0]        cfg_addr;
    logic [DW-1:0]     cfg_wdata;
    logic              cfg_err;
    logic [DW-1:0]     out_V;
    logic              out_V_ap_vld;

    int passed = 0;
    int total  = 0;

    dense_mac_sequencer #(
        .N_IN (N_IN),
        .DW   (DW),
        .FRAC (10)
    ) dut (
        .ap_clk         (ap_clk),
        .ap_rst         (ap_rst),
        .ap_start       (ap_start),
        .ap_done        (ap_done),
        .ap_idle        (ap_idle),
        .ap_ready       (ap_ready),
        .input_V_ap_vld (input_V_ap_vld),
        .input_V        (input_V),
        .cfg_we         (cfg_we),
        .cfg_addr       (cfg_addr),
        .cfg_wdata      (cfg_wdata),
        .cfg_err        (cfg_err),
        .out_V          (out_V),
        .out_V_ap_vld   (out_V_ap_vld)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    endtask

    task automatic next_cycle();
        @(posedge ap_clk);
        #1;
    endtask

    // One inference from IDLE: capture in cycle 0, ap_done in cycle 4
    task automatic run(input logic [15:0] x0, input logic [15:0] x1,
                       input logic [15:0] expv, input string tag);
        ap_start       = 1'b1;
        input_V_ap_vld = 1'b1;
        input_V        = {x1, x0};
        #1;
        chk({tag, "_ready_c0"}, ap_ready, 1);
        chk({tag, "_idle_c0"}, ap_idle, 1);
        next_cycle();
        ap_start       = 1'b0;
        input_V_ap_vld = 1'b0;
        cfg_we         = 1'b0;
        input_V        = '1;
        #1;
        chk({tag, "_cfgerr_c1"}, cfg_err, 0);
        for (int c = 1; c <= 3; c++) begin
            chk({tag, "_ready_busy"}, ap_ready, 0);
            chk({tag, "_done_early"}, ap_done, 0);
            chk({tag, "_idle_busy"}, ap_idle, 0);
            next_cycle();
        end
        chk({tag, "_done_c4"}, ap_done, 1);
        chk({tag, "_vld_c4"}, out_V_ap_vld, 1);
        chk({tag, "_out"}, out_V, expv);
        next_cycle();
        chk({tag, "_done_c5"}, ap_done, 0);
        chk({tag, "_idle_c5"}, ap_idle, 1);
        chk({tag, "_out_held"}, out_V, expv);
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [15:0] d,
                             input logic exp_err, input string tag);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        next_cycle();
        cfg_we = 1'b0;
        #1;
        chk({tag, "_err"}, cfg_err, exp_err);
        chk({tag, "_idle"}, ap_idle, 1);
        next_cycle();
        chk({tag, "_err_clr"}, cfg_err, 0);
    endtask

    initial begin
        ap_rst         = 1'b1;
        ap_start       = 1'b0;
        input_V_ap_vld = 1'b0;
        input_V        = '0;
        cfg_we         = 1'b0;
        cfg_addr       = '0;
        cfg_wdata      = '0;

        // Reset state
        repeat (2) @(posedge ap_clk);
        #1;
        chk("rst_idle", ap_idle, 1);
        chk("rst_done", ap_done, 0);
        chk("rst_ready", ap_ready, 0);
        chk("rst_out", out_V, 0);
        chk("rst_vld", out_V_ap_vld, 0);
        chk("rst_cfgerr", cfg_err, 0);
        ap_rst = 1'b0;
        next_cycle();

        // Defaults w0=-288 w1=304 b=157: -29 + 59 + 157 = 187
        run(16'd100, 16'd200, 16'd187, "t1");
        // -288 + 304 + 157 = 173
        run(16'd1024, 16'd1024, 16'd173, "t2");
        // 288 + 0 + 157 = 445
        run(16'hFC00, 16'd0, 16'd445, "t3");

        // Bias 0x7FFF: 304 + 32767 wraps to 0x812F
        cfg_write(2'd2, 16'h7FFF, 1'b0, "wbias");
        run(16'd0, 16'd1024, 16'h812F, "t4");
        // Out-of-range address is dropped
        cfg_write(2'd3, 16'h0000, 1'b1, "badaddr");
        run(16'd0, 16'd1024, 16'h812F, "t5");

        // Write in the capture cycle restores bias and is used by this run
        cfg_we    = 1'b1;
        cfg_addr  = 2'd2;
        cfg_wdata = 16'd157;
        run(16'd100, 16'd200, 16'd187, "t6");

        // ap_start held: captures at 0,5,10 and done at 4,9,14
        ap_start       = 1'b1;
        input_V_ap_vld = 1'b1;
        input_V        = {16'd200, 16'd100};
        for (int c = 0; c < 15; c++) begin
            #1;
            chk("hold_done", ap_done, (c == 4 || c == 9 || c == 14));
            chk("hold_ready", ap_ready, (c % 5 == 0));
            if (c % 5 == 4) chk("hold_out", out_V, 16'd187);
            next_cycle();
        end
        ap_start = 1'b0;
        next_cycle();

        // ap_start without valid input: no capture
        ap_start       = 1'b1;
        input_V_ap_vld = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("novld_ready", ap_ready, 0);
            chk("novld_idle", ap_idle, 1);
            next_cycle();
        end
        ap_start = 1'b0;

        // Weight write during MAC is dropped, result unchanged
        ap_start       = 1'b1;
        input_V_ap_vld = 1'b1;
        input_V        = {16'd200, 16'd100};
        #1;
        chk("macw_ready", ap_ready, 1);
        next_cycle();
        ap_start       = 1'b0;
        input_V_ap_vld = 1'b0;
        cfg_we         = 1'b1;
        cfg_addr       = 2'd0;
        cfg_wdata      = 16'd0;
        next_cycle();
        cfg_we = 1'b0;
        #1;
        chk("macw_err", cfg_err, 1);
        next_cycle();
        chk("macw_err_clr", cfg_err, 0);
        next_cycle();
        chk("macw_done", ap_done, 1);
        chk("macw_out", out_V, 16'd187);
        next_cycle();
        run(16'd100, 16'd200, 16'd187, "t7");

        // Reset asserted in BIAS aborts the run and restores weights
        cfg_write(2'd0, 16'd0, 1'b0, "w0zero");
        ap_start       = 1'b1;
        input_V_ap_vld = 1'b1;
        input_V        = {16'd200, 16'd100};
        next_cycle();
        ap_start       = 1'b0;
        input_V_ap_vld = 1'b0;
        next_cycle();
        next_cycle();
        ap_rst = 1'b1;
        #1;
        chk("abort_out", out_V, 0);
        chk("abort_done", ap_done, 0);
        chk("abort_idle", ap_idle, 1);
        chk("abort_vld", out_V_ap_vld, 0);
        next_cycle();
        ap_rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("abort_nodone", ap_done, 0);
            next_cycle();
        end
        run(16'd100, 16'd200, 16'd187, "revert");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dense_mac_sequencer.md
Name: dense_mac_sequencer

Overview:
Time-multiplexed controller for a single-neuron dense layer. One shared signed 16x16 multiplier and accumulator serve all N_IN inputs, one per cycle, under an FSM. The FSM adds the bias and presents the 16-bit fixed-point result with the ap_start/ap_done/ap_idle/ap_ready handshake used by the generated layers. Weights and bias are runtime-configurable through a small write port.

Parameters:
N_IN, 2, number of inputs and weights (>=1)
DW, 16, data/weight/bias width, signed two's complement
FRAC, 10, product right-shift (fractional bits of weights)
W_RST, {16'sd304, -16'sd288}, packed reset weights, w[i] at [i*DW +: DW]
B_RST, 16'sd157, reset bias

Ports:
ap_clk  in  1  clock, rising edge
ap_rst  in  1  reset, asynchronous, active-high
ap_start  in  1  request to run one inference
ap_done  out  1  one-cycle pulse, result valid
ap_idle  out  1  high in IDLE
ap_ready  out  1  high in the cycle input is captured
input_V_ap_vld  in  1  input_V valid
input_V  in  N_IN*DW  packed inputs, x[i] at [i*DW +: DW]
cfg_we  in  1  config write strobe
cfg_addr  in  clog2(N_IN+1)  0..N_IN-1 = weight index, N_IN = bias
cfg_wdata  in  DW  config data
cfg_err  out  1  registered one-cycle pulse, write dropped
out_V  out  DW  result, held until next result
out_V_ap_vld  out  1  equals ap_done

Behaviour:
- Reset (async assert, sync release): state=IDLE, idx=0, acc=0, out_V=0, ap_done=0, out_V_ap_vld=0, cfg_err=0, w[i]=W_RST, bias=B_RST, input register=0. Reset mid-run aborts and produces no ap_done.
- States: IDLE, MAC, BIAS, DONE.
- IDLE: ap_idle=1. If ap_start && input_V_ap_vld, the FSM latches input_V, clears acc and idx, goes to MAC, and ap_ready=1 combinationally in that cycle. ap_start without valid input: stay in IDLE, ap_ready=0.
- MAC: one term per cycle. p = w[idx]*x[idx] is full signed 2*DW. term = p[FRAC+DW-1:FRAC], which is an arithmetic shift (floor) with the upper bits discarded. acc = acc+term, DW-bit wrap. idx increments; after idx==N_IN-1, go to BIAS.
- BIAS: out_V <= acc + bias (DW-bit wrap, no saturation). Go to DONE.
- DONE: ap_done=out_V_ap_vld=1 for exactly this cycle. Return to IDLE.
- Latency: capture cycle = 0; ap_done is high in cycle N_IN+2 (4 for the defaults). Max throughput is one result per N_IN+3 cycles. With ap_start held high, the next capture happens in the IDLE cycle right after DONE.
- ap_start and input_V are ignored outside IDLE. input_V may change after capture.
- Config writes take effect at the clock edge and only in IDLE.
  - cfg_we in IDLE with cfg_addr > N_IN: no change, cfg_err=1.
  - cfg_we outside IDLE: no change, cfg_err=1.
  - cfg_we in the same IDLE cycle as a capture: the write is applied and the new run uses the new value.
- Outputs other than ap_ready/ap_idle/ap_done are registered. ap_idle and ap_done decode directly from state.

Test Plan:
- Defaults, x0=100, x1=200 (input_V=0x00C8_0064) -> terms -29 and 59; out_V=187 (0x00BB); ap_done pulse in cycle 4; ap_ready high in cycle 0 only.
- x0=1024, x1=1024 -> -288+304+157 = out_V=173. Then x0=0xFC00 (-1024), x1=0 -> out_V=445.
- Write bias=0x7FFF (addr 2), x0=0, x1=1024 -> wrap, out_V=0x812F. Then write addr 3 -> cfg_err pulse, no state change.
- ap_start held high with input_V_ap_vld=1 for 3 runs -> ap_done in cycles 4, 9, 14. Drive input_V_ap_vld=0 with ap_start=1 -> stays IDLE, no ap_ready.
- cfg_we w0=0 during MAC -> cfg_err=1 and the current result is unchanged (187 for the first test inputs). Assert ap_rst in the BIAS cycle -> outputs return to reset values immediately, no ap_done, and weights revert to -288/304.
